dmem_resp: RTL and testbench

Wait-state data-memory responder for the MIPS data port. It answers the processor's `MemRead`/`MemWrite` requests from a word-organised storage array after a programmable number of wait states, and signals completion with a one-cycle `ready` pulse. It sits between the `mips` data-port outputs (`aluout`, `rd2`, `MemRead`, `MemWrite`) and `dmemout`. It is the multi-cycle counterpart of the zero-latency `dmem` model and lets the stall path of the core be exercised.

---
 rtl/dmem_resp_if.sv | 32 +++
 rtl/dmem_resp.sv | 151 +++++++++++++++
 tb/tb_dmem_resp.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - data-port bundle between the MIPS core and dmem_resp
//
// Purpose: groups the request/response signals of the core's data port.
// Ports (signals):
//   addr     [31:0]  byte address (core -> memory)
//   wrdata   [31:0]  store data   (core -> memory)
//   MemRead          load request, level (core -> memory)
//   MemWrite         store request, level (core -> memory)
//   rddata   [31:0]  registered load data (memory -> core)
//   ready            one-cycle completion pulse (memory -> core)
//   err              access rejected, valid with ready (memory -> core)
//   busy             request held (memory -> core)
interface dmem_resp_if;
  logic [31:0] addr;
  logic [31:0] wrdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rddata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output addr, wrdata, MemRead, MemWrite,
    input  rddata, ready, err, busy
  );

  modport slave (
    input  addr, wrdata, MemRead, MemWrite,
    output rddata, ready, err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-state data-memory responder for the MIPS data port
//
// Purpose: answers MemRead/MemWrite requests from a word-organised array
// after WAIT_CYCLES wait states and signals completion with a ready pulse.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    dmem_resp_if.slave: addr/wrdata/MemRead/MemWrite in,
//          rddata/ready/err/busy out
module dmem_resp #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  dmem_resp_if.slave bus
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rddata_q, rddata_d;
  logic        err_q, err_d;

  logic [31:0] mcell [0:DEPTH_WORDS-1];

  // Request seen by the access logic. With WAIT_CYCLES=0 the capture edge is
  // also the RESP-entry edge, so the live inputs must be used directly in IDLE.
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wrdata;
  logic             acc_rd;
  logic             acc_wr;
  logic             acc_misaligned;
  logic             acc_out_of_range;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             enter_resp;
  logic             mem_we;

  assign acc_addr   = (state_q == ST_IDLE) ? bus.addr     : addr_q;
  assign acc_wrdata = (state_q == ST_IDLE) ? bus.wrdata   : wrdata_q;
  assign acc_rd     = (state_q == ST_IDLE) ? bus.MemRead  : rd_q;
  assign acc_wr     = (state_q == ST_IDLE) ? bus.MemWrite : wr_q;
  assign acc_idx    = acc_addr[IDX_W+1:2];

  // Any set bit above the word index means addr >= 4*DEPTH_WORDS.
  assign acc_misaligned   = (acc_addr[1:0] != 2'b00);
  assign acc_out_of_range = (acc_addr[31:IDX_W+2] != '0);
  assign acc_err          = acc_misaligned | acc_out_of_range | (acc_rd & acc_wr);

  // The access happens exactly on the edge that moves the FSM into RESP.
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign mem_we     = enter_resp && acc_wr && !acc_err;

  // State register, capture registers, response registers and storage.
  // Storage sits in the reset process only so that a write is suppressed
  // while reset is held; it is never cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rddata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rddata_q <= rddata_d;
      err_q    <= err_d;
      if (mem_we) begin
        mcell[acc_idx] <= acc_wrdata;
      end
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          addr_d   = bus.addr;
          wrdata_d = bus.wrdata;
          rd_d     = bus.MemRead;
          wr_d     = bus.MemWrite;
          cnt_d    = WAIT_INIT;
          state_d  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response data: loaded only on RESP entry; a write leaves rddata alone.
  always_comb begin
    rddata_d = rddata_q;
    if (enter_resp) begin
      if (acc_err) begin
        rddata_d = '0;
      end else if (acc_rd) begin
        rddata_d = mcell[acc_idx];
      end
    end
    err_d = enter_resp && acc_err;
  end

  // Outputs.
  always_comb begin
    bus.ready  = (state_q == ST_RESP);
    bus.busy   = (state_q != ST_IDLE);
    bus.err    = err_q && (state_q == ST_RESP);
    bus.rddata = rddata_q;
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - randomized model-checked bench for dmem_resp
module tb_dmem_resp;
  localparam int DEPTH = 64;

  logic clock;
  logic reset;

  dmem_resp_if b0 ();
  dmem_resp_if b1 ();

  logic [31:0] a_s [2];
  logic [31:0] w_s [2];
  logic        rd_s [2];
  logic        wr_s [2];
  logic [1:0]  o_rdy, o_err, o_busy;
  logic [31:0] o_rd [2];

  assign b0.addr = a_s[0];  assign b0.wrdata = w_s[0];
  assign b0.MemRead = rd_s[0];  assign b0.MemWrite = wr_s[0];
  assign b1.addr = a_s[1];  assign b1.wrdata = w_s[1];
  assign b1.MemRead = rd_s[1];  assign b1.MemWrite = wr_s[1];
  assign o_rdy[0] = b0.ready;  assign o_err[0] = b0.err;
  assign o_busy[0] = b0.busy;  assign o_rd[0] = b0.rddata;
  assign o_rdy[1] = b1.ready;  assign o_err[1] = b1.err;
  assign o_busy[1] = b1.busy;  assign o_rd[1] = b1.rddata;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u0 (.clock(clock), .reset(reset), .bus(b0));
  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u1 (.clock(clock), .reset(reset), .bus(b1));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wlat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference model: a request captured at edge k is answered at edge k+W,
  // and the next capture is possible at edge k+W+2.
  logic [31:0] m_mem [2][DEPTH];
  logic [31:0] m_rd [2];
  logic        m_rdy [2];
  logic        m_err [2];
  int          resp_at [2];
  int          free_at [2];
  logic [31:0] c_addr [2];
  logic [31:0] c_wd [2];
  logic        c_r [2];
  logic        c_w [2];
  int          edge_n;

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_rd[d] = '0; m_rdy[d] = 1'b0; m_err[d] = 1'b0;
      resp_at[d] = -1; free_at[d] = 0;
    end
  endtask

  initial begin
    edge_n = 0;
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_clear();
      end else begin
        edge_n++;
        for (int d = 0; d < 2; d++) begin
          logic bad;
          m_rdy[d] = 1'b0;
          m_err[d] = 1'b0;
          if (edge_n >= free_at[d] && (rd_s[d] || wr_s[d])) begin
            c_addr[d] = a_s[d]; c_wd[d] = w_s[d]; c_r[d] = rd_s[d]; c_w[d] = wr_s[d];
            resp_at[d] = edge_n + wlat(d);
            free_at[d] = resp_at[d] + 2;
          end
          if (resp_at[d] == edge_n) begin
            bad = (c_addr[d] % 4 != 0) || (c_addr[d] >= 32'(4 * DEPTH)) || (c_r[d] && c_w[d]);
            m_rdy[d] = 1'b1;
            m_err[d] = bad;
            if (bad) m_rd[d] = '0;
            else if (c_w[d]) m_mem[d][c_addr[d] / 4] = c_wd[d];
            else m_rd[d] = m_mem[d][c_addr[d] / 4];
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output of both instances.
  initial begin
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), 32'(o_rdy[d]), 32'(m_rdy[d]));
        chk($sformatf("err%0d", d), 32'(o_err[d]), 32'(m_err[d]));
        chk($sformatf("busy%0d", d), 32'(o_busy[d]), 32'(resp_at[d] >= edge_n));
        chk($sformatf("rddata%0d", d), o_rd[d], m_rd[d]);
      end
    end
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drives one request (from a negedge) and waits for its ready pulse.
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic r, input logic w, input logic scr,
                      output logic [31:0] rv, output logic ev, output int t);
    a_s[d] = a; w_s[d] = wd; rd_s[d] = r; wr_s[d] = w;
    t = 0;
    do begin
      @(negedge clock);
      t++;
      if (scr && t == 1 && !o_rdy[d]) begin
        a_s[d] = $urandom; w_s[d] = $urandom;
      end
    end while (!o_rdy[d] && t < 40);
    chk($sformatf("ready_seen%0d", d), 32'(o_rdy[d]), 32'd1);
    rv = o_rd[d];
    ev = o_err[d];
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
  endtask

  logic [31:0] init_val [DEPTH];

  initial begin
    logic [31:0] rv;
    logic        ev;
    int          t;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      a_s[d] = '0; w_s[d] = '0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy0", 32'(o_busy[0]), 32'd0);
    chk("rst_ready0", 32'(o_rdy[0]), 32'd0);
    chk("rst_err0", 32'(o_err[0]), 32'd0);
    chk("rst_rddata0", o_rd[0], 32'd0);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) init_val[i] = $urandom;
    init_val[0] = 32'd56; init_val[1] = 32'd10; init_val[2] = 32'd1;
    fork
      begin
        logic [31:0] r0; logic e0; int t0;
        for (int i = 0; i < DEPTH; i++) xact(0, 32'(i * 4), init_val[i], 1'b0, 1'b1, 1'b0, r0, e0, t0);
      end
      begin
        logic [31:0] r1; logic e1; int t1;
        for (int i = 0; i < DEPTH; i++) xact(1, 32'(i * 4), init_val[i], 1'b0, 1'b1, 1'b0, r1, e1, t1);
      end
    join

    // Read of word 1 with two wait states.
    @(negedge clock);
    xact(0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("lat_w2", 32'(t), 32'd3);
    chk("rd_w1", rv, 32'd10);
    chk("rd_w1_err", 32'(ev), 32'd0);
    @(negedge clock);
    chk("idle_after_resp", 32'(o_busy[0]), 32'd0);

    // Write then read back.
    xact(0, 32'hC, 32'd560, 1'b0, 1'b1, 1'b0, rv, ev, t);
    chk("wr_err", 32'(ev), 32'd0);
    @(negedge clock);
    xact(0, 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("rd_back", rv, 32'd560);
    chk("rd_back_err", 32'(ev), 32'd0);
    chk("mcell3", u0.mcell[3], 32'd560);
    chk("model_mcell3", m_mem[0][3], 32'd560);

    // Error cases.
    @(negedge clock);
    xact(0, 32'h6, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("misalign_err", 32'(ev), 32'd1);
    chk("misalign_rd", rv, 32'd0);
    @(negedge clock);
    xact(0, 32'h100, 32'h1234, 1'b0, 1'b1, 1'b0, rv, ev, t);
    chk("oor_err", 32'(ev), 32'd1);
    @(negedge clock);
    xact(0, 32'h8, 32'h5555, 1'b1, 1'b1, 1'b0, rv, ev, t);
    chk("both_err", 32'(ev), 32'd1);
    chk("both_no_write", u0.mcell[2], 32'd1);

    // Address changed during WAIT must not affect the access.
    @(negedge clock);
    a_s[0] = 32'h0; rd_s[0] = 1'b1;
    @(negedge clock);
    a_s[0] = 32'h8;
    t = 1;
    while (!o_rdy[0] && t < 40) begin @(negedge clock); t++; end
    chk("captured_addr", o_rd[0], 32'd56);
    rd_s[0] = 1'b0;

    // Reset during WAIT discards the write.
    @(negedge clock);
    @(negedge clock);
    a_s[0] = 32'h10; w_s[0] = 32'hDEAD; wr_s[0] = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", 32'(o_busy[0]), 32'd0);
    chk("async_ready", 32'(o_rdy[0]), 32'd0);
    chk("async_rddata", o_rd[0], 32'd0);
    wr_s[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("mcell4_kept", u0.mcell[4], init_val[4]);
    xact(0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("rd_after_rst", rv, init_val[4]);

    // Back-to-back reads with zero wait states.
    @(negedge clock);
    xact(1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("b2b_lat0", 32'(t), 32'd1);
    chk("b2b_rd0", rv, 32'd56);
    chk("b2b_err0", 32'(ev), 32'd0);
    xact(1, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("b2b_period1", 32'(t), 32'd2);
    chk("b2b_rd1", rv, 32'd10);
    xact(1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, rv, ev, t);
    chk("b2b_period2", 32'(t), 32'd2);
    chk("b2b_rd2", rv, 32'd1);
    chk("b2b_err2", 32'(ev), 32'd0);

    // Randomized traffic on both instances.
    fork
      for (int d = 0; d < 2; d++) begin
        automatic int dd = d;
        fork
          begin
            logic [31:0] ra, rw, rr; logic r, w, re; int rt, op;
            for (int n = 0; n < 200; n++) begin
              op = $urandom_range(0, 9);
              ra = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
              rw = $urandom; r = 1'b0; w = 1'b0;
              if (op <= 3) r = 1'b1;
              else if (op <= 6) w = 1'b1;
              else if (op == 7) begin
                ra[1:0] = 2'($urandom_range(1, 3)); r = 1'($urandom_range(0, 1)); w = !r;
              end else if (op == 8) begin
                ra = ($urandom | 32'h100) & 32'hFFFF_FFFC; w = 1'($urandom_range(0, 1)); r = !w;
              end else begin
                r = 1'b1; w = 1'b1;
              end
              xact(dd, ra, rw, r, w, 1'($urandom_range(0, 1)), rr, re, rt);
              repeat ($urandom_range(0, 2)) @(negedge clock);
            end
          end
        join_none
      end
      wait fork;
    join

    repeat (4) @(negedge clock);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("mcell0_%0d", i), u0.mcell[i], m_mem[0][i]);
      chk($sformatf("mcell1_%0d", i), u1.mcell[i], m_mem[1][i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
